// File: rtl/grev_issue_ctrl.sv
// Issue controller for a fixed-latency grev unit: registers operands,
// tracks in-flight ops and buffers results in a credit-managed FIFO.
module grev_issue_ctrl #(
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [3:0]  in_tag,
    output logic [31:0] grev_rs1,
    output logic [4:0]  grev_rs2,
    input  logic [31:0] grev_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rd,
    output logic [3:0]  out_tag,
    output logic        busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = CW + 4;

    logic [LATENCY-1:0] vld_q;
    logic [3:0]         tag_q   [LATENCY];
    logic [31:0]        rd_mem  [FIFO_DEPTH];
    logic [3:0]         tag_mem [FIFO_DEPTH];
    logic [AW-1:0]      wptr_q;
    logic [AW-1:0]      rptr_q;
    logic [CW-1:0]      count_q;
    logic [SW-1:0]      inflight;
    logic               accept;
    logic               push;
    logic               pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + SW'(vld_q[i]);
        end
    end

    // Credits come from registered counts only, so a pop frees a slot
    // for in_ready one cycle later.
    assign in_ready  = (SW'(count_q) + inflight) < SW'(FIFO_DEPTH);
    assign accept    = in_valid && in_ready;
    assign push      = vld_q[LATENCY-1];
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_rd    = rd_mem[rptr_q];
    assign out_tag   = tag_mem[rptr_q];
    assign busy      = (inflight != '0) || out_valid;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            grev_rs1 <= '0;
            grev_rs2 <= '0;
        end else if (accept) begin
            grev_rs1 <= in_rs1;
            grev_rs2 <= in_rs2;
        end
    end

    // The grev unit never stalls, so the tracking pipe always shifts.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
            vld_q[0] <= accept;
            tag_q[0] <= in_tag;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rd_mem[i]  <= '0;
                tag_mem[i] <= '0;
            end
        end else if (push) begin
            rd_mem[wptr_q]  <= grev_rd;
            tag_mem[wptr_q] <= tag_q[LATENCY-1];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_overflow: assert property (
        @(posedge clock) disable iff (!resetn)
        !(push && (count_q == CW'(FIFO_DEPTH)))
    );

endmodule
